io_bus_uart: RTL and testbench

//  Memory-mapped 8N1 UART slave on the 16-bit IO bridge (io_* bus) of CPEN391_Computer.

---
 rtl/io_uart_pkg.sv | 58 +++++
 rtl/io_uart_fifo.sv | 64 ++++++
 rtl/io_bus_uart.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_io_bus_uart.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module     : io_uart_pkg
// Description: Shared definitions for the io_bus UART. Contains register word
//              offsets, STATUS/CONTROL bit indices, the minimum effective
//              divisor and the state encodings for the bus, TX and RX FSMs.
// Revision   : 1.0 - initial release
// ============================================================================
package io_uart_pkg;

    // Register word offsets, indexed by io_address[2:1]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_TX_IDLE      = 2;
    localparam int ST_OVERRUN      = 3;
    localparam int ST_FRAME_ERR    = 4;

    // CONTROL bit positions
    localparam int CTRL_RX_IEN   = 0;
    localparam int CTRL_TX_IEN   = 1;
    localparam int CTRL_LOOPBACK = 2;

    // Shortest bit period the shifters will run at
    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        BUS_IDLE      = 2'd0,
        BUS_ACK       = 2'd1,
        BUS_WAIT_DROP = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Programmed divisor clamped to the minimum usable bit period
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module     : io_uart_fifo
// Description: Synchronous show-ahead FIFO. rdata_o presents the head entry
//              whenever empty_o is low. A push while full is accepted only
//              when a pop happens in the same cycle (count unchanged);
//              otherwise it is dropped. Pops while empty are ignored.
// Ports      : clk, reset_n (async active-low)
//              push_i/wdata_i  - write side
//              pop_i/rdata_o   - read side
//              full_o, empty_o, count_o - occupancy
// Revision   : 1.0 - initial release
// ============================================================================
module io_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];

    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage carries no reset; only entries behind the pointers are visible
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/io_bus_uart.sv
`default_nettype none
// ============================================================================
// Module     : io_bus_uart
// Description: 8N1 UART slave on the 16-bit io_* bridge. Four-register window
//              (DATA, STATUS, CONTROL, DIVISOR) at BASE_ADDR..BASE_ADDR+7,
//              TX/RX FIFOs of FIFO_DEPTH bytes, registered level interrupt.
// Ports      : clk, reset_n (async active-low)
//              io_address/io_bus_enable/io_byte_enable/io_rw/io_write_data
//              - bridge request; io_read_data/io_acknowledge - completion
//              io_irq - interrupt; uart_txd/uart_rxd - serial line
// Config     : IO_UART_LOOPBACK_EN - enables CONTROL[2] internal loopback
// Revision   : 1.0 - initial release
// ============================================================================
module io_bus_uart
    import io_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0200,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic [1:0]  io_byte_enable,
    input  logic        io_rw,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------ bus
    bus_state_t  bus_state_q, bus_state_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] w_rd_mux, w_status, w_div_eff;
    logic [2:0]  w_ctrl_rd;
    logic [1:0]  w_word;
    logic        w_hit, w_accept, w_wr, w_rd, w_loop;
    logic        w_unused;

    // CSR state
    logic [1:0]  ctrl_q;
    logic [15:0] div_q;
    logic        overrun_q, frame_q, irq_q;

    // FIFO hookup
    logic          w_tx_push, w_tx_pop, tx_full, tx_empty;
    logic          w_rx_push, w_rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_rdata, rx_rdata;
    logic [CW-1:0] tx_count, rx_count;

    // TX shifter
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d, w_tx_idle;

    // RX shifter
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q, w_rx_in;
    logic        w_frame_set, w_overrun_set;

    assign w_unused = io_address[0];   // byte lane select is ignored

    assign w_word   = io_address[2:1];
    assign w_hit    = (io_address[15:3] == BASE_ADDR[15:3]);
    assign w_accept = (bus_state_q == BUS_IDLE) & io_bus_enable & w_hit;
    assign w_wr     = w_accept & ~io_rw;
    assign w_rd     = w_accept & io_rw;

    always_comb begin
        bus_state_d = bus_state_q;
        case (bus_state_q)
            BUS_IDLE:      if (w_accept) bus_state_d = BUS_ACK;
            BUS_ACK:       bus_state_d = BUS_WAIT_DROP;
            BUS_WAIT_DROP: if (!io_bus_enable) bus_state_d = BUS_IDLE;
            default:       bus_state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        w_status                  = '0;
        w_status[ST_RX_NOT_EMPTY] = ~rx_empty;
        w_status[ST_TX_NOT_FULL]  = ~tx_full;
        w_status[ST_TX_IDLE]      = w_tx_idle;
        w_status[ST_OVERRUN]      = overrun_q;
        w_status[ST_FRAME_ERR]    = frame_q;
        w_status[15:8]            = 8'(rx_count);
    end

    always_comb begin
        w_ctrl_rd                = '0;
        w_ctrl_rd[CTRL_RX_IEN]   = ctrl_q[0];
        w_ctrl_rd[CTRL_TX_IEN]   = ctrl_q[1];
        w_ctrl_rd[CTRL_LOOPBACK] = w_loop;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_word)
            REG_DATA:    w_rd_mux = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
            REG_STATUS:  w_rd_mux = w_status;
            REG_CONTROL: w_rd_mux = {13'h0000, w_ctrl_rd};
            REG_DIVISOR: w_rd_mux = div_q;
            default:     w_rd_mux = '0;
        endcase
        // Data is captured on accept and is non-zero only during the ACK cycle
        rdata_d = w_rd ? w_rd_mux : 16'h0000;
    end

    assign io_read_data   = rdata_q;
    assign io_acknowledge = (bus_state_q == BUS_ACK);
    assign io_irq         = irq_q;

    // All register side effects fire on the single accept cycle
    assign w_tx_push = w_wr & (w_word == REG_DATA) & io_byte_enable[0];
    assign w_rx_pop  = w_rd & (w_word == REG_DATA) & ~rx_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_state_q <= BUS_IDLE;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            div_q       <= DEFAULT_DIV;
            overrun_q   <= 1'b0;
            frame_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            bus_state_q <= bus_state_d;
            rdata_q     <= rdata_d;
            if (w_wr && w_word == REG_CONTROL && io_byte_enable[0])
                ctrl_q <= {io_write_data[CTRL_TX_IEN], io_write_data[CTRL_RX_IEN]};
            if (w_wr && w_word == REG_DIVISOR) begin
                if (io_byte_enable[0]) div_q[7:0]  <= io_write_data[7:0];
                if (io_byte_enable[1]) div_q[15:8] <= io_write_data[15:8];
            end
            // A new error in the same cycle as a clear wins
            if (w_overrun_set)
                overrun_q <= 1'b1;
            else if (w_wr && w_word == REG_STATUS && io_byte_enable[0]
                     && io_write_data[ST_OVERRUN])
                overrun_q <= 1'b0;
            if (w_frame_set)
                frame_q <= 1'b1;
            else if (w_wr && w_word == REG_STATUS && io_byte_enable[0]
                     && io_write_data[ST_FRAME_ERR])
                frame_q <= 1'b0;
            irq_q <= (ctrl_q[0] & (~rx_empty | overrun_q | frame_q))
                   | (ctrl_q[1] & w_tx_idle);
        end
    end

    // ------------------------------------------------------------- loopback
`ifdef IO_UART_LOOPBACK_EN
    logic loop_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            loop_q <= 1'b0;
        else if (w_wr && w_word == REG_CONTROL && io_byte_enable[0])
            loop_q <= io_write_data[CTRL_LOOPBACK];
    end
    assign w_loop   = loop_q;
    assign uart_txd = loop_q ? 1'b1 : txd_q;
    // Internal txd is already synchronous, so it skips the synchroniser
    assign w_rx_in  = loop_q ? txd_q : rx_sync_q;
`else
    assign w_loop   = 1'b0;
    assign uart_txd = txd_q;
    assign w_rx_in  = rx_sync_q;
`endif

    // ---------------------------------------------------------------- FIFOs
    io_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_tx_push),
        .wdata_i (io_write_data[7:0]),
        .pop_i   (w_tx_pop),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    io_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_rx_push),
        .wdata_i (rx_shift_q),
        .pop_i   (w_rx_pop),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // ------------------------------------------------------------------- TX
    // Counters reload at every bit boundary, so a DIVISOR write takes effect
    // on the next bit without disturbing the bit in flight.
    assign w_div_eff = eff_div(div_q);
    assign w_tx_idle = tx_empty & (tx_state_q == TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!tx_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_shift_d = tx_rdata;
                    tx_cnt_d   = w_div_eff - 16'd1;
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = w_div_eff - 16'd1;
                    tx_idx_d   = 3'd0;
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = w_div_eff - 16'd1;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (!tx_empty) begin
                        // Chain straight into the next start bit, no idle gap
                        w_tx_pop   = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_cnt_d   = w_div_eff - 16'd1;
                        tx_state_d = TX_START;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        txd_d      = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------- RX
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        w_rx_push   = 1'b0;
        w_frame_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !w_rx_in) begin
                    rx_cnt_d   = (w_div_eff >> 1) - 16'd1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    // Line back high at mid start bit means a glitch
                    if (!w_rx_in) begin
                        rx_cnt_d   = w_div_eff - 16'd1;
                        rx_idx_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {w_rx_in, rx_shift_q[7:1]};
                    rx_cnt_d   = w_div_eff - 16'd1;
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    w_rx_push   = w_rx_in;
                    w_frame_set = ~w_rx_in;
                    rx_state_d  = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // The FIFO accepts a push while full only alongside a bus pop
    assign w_overrun_set = w_rx_push & rx_full & ~w_rx_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= uart_rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= w_rx_in;
        end
    end

    logic w_unused_cnt;
    assign w_unused_cnt = ^tx_count;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_uart.sv
`default_nettype none
// ============================================================================
// Module     : tb_io_bus_uart
// Description: Directed self-checking bench for io_bus_uart (default build,
//              loopback macro undefined). Each scenario task drives the bus
//              and/or serial line and compares against hand-computed values.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_io_bus_uart;

    localparam logic [15:0] A_DATA = 16'h0200;
    localparam logic [15:0] A_STAT = 16'h0202;
    localparam logic [15:0] A_CTRL = 16'h0204;
    localparam logic [15:0] A_DIV  = 16'h0206;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] io_address = '0;
    logic        io_bus_enable = 1'b0;
    logic [1:0]  io_byte_enable = '0;
    logic        io_rw = 1'b0;
    logic [15:0] io_write_data = '0;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_bus_uart dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_address     (io_address),
        .io_bus_enable  (io_bus_enable),
        .io_byte_enable (io_byte_enable),
        .io_rw          (io_rw),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_acknowledge (io_acknowledge),
        .io_irq         (io_irq),
        .uart_txd       (uart_txd),
        .uart_rxd       (uart_rxd)
    );

    // ---------------------------------------------------------- bus drivers
    task automatic bus_start(input logic [15:0] a, input logic rw,
                             input logic [1:0] be, input logic [15:0] d);
        @(posedge clk); #1;
        io_address     = a;
        io_rw          = rw;
        io_byte_enable = be;
        io_write_data  = d;
        io_bus_enable  = 1'b1;
    endtask

    task automatic bus_wait_ack(output logic [15:0] d);
        bit got = 0;
        d = 16'hxxxx;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (io_acknowledge) begin
                got = 1;
                d   = io_read_data;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL bus_ack_timeout addr=%h: no acknowledge within 20 clk", io_address);
        end
    endtask

    task automatic bus_finish();
        @(posedge clk); #1;
        io_bus_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus_start(a, 1'b1, 2'b11, 16'h0000);
        bus_wait_ack(d);
        bus_finish();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] dummy;
        bus_start(a, 1'b0, be, d);
        bus_wait_ack(dummy);
        bus_finish();
    endtask

    // One serial bit at 8 clocks per bit
    task automatic drive_bit(input logic v);
        @(posedge clk); #1;
        uart_rxd = v;
        repeat (7) @(posedge clk);
    endtask

    task automatic send_rx_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        logic [15:0] rd;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        total++; if (io_acknowledge !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", io_acknowledge); end
        total++; if (io_read_data !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", io_read_data); end
        total++; if (io_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", io_irq); end
        total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", uart_txd); end
        // Start a frame at the default 434-clk bit, then reset inside its start bit
        bus_write(A_DATA, 2'b01, 16'h0000);
        repeat (100) @(negedge clk);
        total++; if (uart_txd !== 1'b0) begin bad++; $display("FAIL midtx_txd_low got=%b want=0", uart_txd); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL async_reset_txd got=%b want=1", uart_txd); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0006) begin bad++; $display("FAIL reset_status got=%h want=0006", rd); end
        bus_read(A_DIV, rd);
        total++; if (rd !== 16'd434) begin bad++; $display("FAIL reset_divisor got=%0d want=434", rd); end
        bus_read(A_CTRL, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_control got=%h want=0000", rd); end
    endtask

    task automatic test_tx();
        logic [15:0] rd;
        logic [7:0]  got;
        int          run;
        int          waitc;
        logic        stopb;
        // 434 = 0x01B2: low byte only, then high byte only
        bus_write(A_DIV, 2'b01, 16'h1208);
        bus_read(A_DIV, rd);
        total++; if (rd !== 16'h0108) begin bad++; $display("FAIL div_low_byte got=%h want=0108", rd); end
        bus_write(A_DIV, 2'b10, 16'h0000);
        bus_read(A_DIV, rd);
        total++; if (rd !== 16'h0008) begin bad++; $display("FAIL div_high_byte got=%h want=0008", rd); end

        bus_start(A_DATA, 1'b0, 2'b01, 16'h0055);
        bus_wait_ack(rd);
        waitc = 0;
        while (uart_txd !== 1'b0 && waitc < 50) begin @(negedge clk); waitc++; end
        run = 0;
        while (uart_txd === 1'b0 && run < 40) begin run++; @(negedge clk); end
        total++; if (run != 8) begin bad++; $display("FAIL tx_start_len got=%0d want=8", run); end
        // Now at the first sample of bit 0; move to mid-bit then step by 8
        repeat (3) @(negedge clk);
        got[0] = uart_txd;
        for (int i = 1; i < 8; i++) begin
            repeat (8) @(negedge clk);
            got[i] = uart_txd;
        end
        repeat (8) @(negedge clk);
        stopb = uart_txd;
        total++; if (got !== 8'h55) begin bad++; $display("FAIL tx_byte got=%h want=55", got); end
        total++; if (stopb !== 1'b1) begin bad++; $display("FAIL tx_stop got=%b want=1", stopb); end
        bus_finish();
        repeat (10) @(negedge clk);
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0006) begin bad++; $display("FAIL tx_idle_status got=%h want=0006", rd); end
    endtask

    task automatic test_back_to_back();
        int run;
        int waitc;
        bus_write(A_DATA, 2'b01, 16'h0000);
        bus_write(A_DATA, 2'b01, 16'h00FF);
        // First frame is all low until its stop bit
        waitc = 0;
        while (uart_txd !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
        run = 0;
        while (uart_txd === 1'b1 && run < 40) begin run++; @(negedge clk); end
        total++; if (run != 8) begin bad++; $display("FAIL b2b_stop_len got=%0d want=8", run); end
        run = 0;
        while (uart_txd === 1'b0 && run < 40) begin run++; @(negedge clk); end
        total++; if (run != 8) begin bad++; $display("FAIL b2b_start_len got=%0d want=8", run); end
        repeat (90) @(negedge clk);
    endtask

    task automatic test_rx();
        logic [15:0] rd;
        send_rx_byte(8'hA3, 1'b1);
        repeat (4) @(posedge clk);
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0107) begin bad++; $display("FAIL rx_status_one got=%h want=0107", rd); end
        bus_read(A_DATA, rd);
        total++; if (rd !== 16'h00A3) begin bad++; $display("FAIL rx_data got=%h want=00a3", rd); end
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0006) begin bad++; $display("FAIL rx_status_empty got=%h want=0006", rd); end
    endtask

    task automatic test_hold_and_miss();
        logic [15:0] rd;
        logic [15:0] ord;
        int          acks;
        send_rx_byte(8'h11, 1'b1);
        send_rx_byte(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        bus_start(A_DATA, 1'b1, 2'b11, 16'h0000);
        acks = 0; rd = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (io_acknowledge === 1'b1) begin acks++; rd = io_read_data; end
        end
        bus_finish();
        total++; if (acks != 1) begin bad++; $display("FAIL hold_ack_count got=%0d want=1", acks); end
        total++; if (rd !== 16'h0011) begin bad++; $display("FAIL hold_data got=%h want=0011", rd); end
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0107) begin bad++; $display("FAIL hold_single_pop got=%h want=0107", rd); end
        bus_read(A_DATA, rd);
        total++; if (rd !== 16'h0022) begin bad++; $display("FAIL hold_second got=%h want=0022", rd); end
        bus_read(A_DATA, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL read_empty got=%h want=0000", rd); end
        // First address past the window
        bus_start(16'h0208, 1'b1, 2'b11, 16'h0000);
        acks = 0; ord = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (io_acknowledge === 1'b1) acks++;
            ord = ord | io_read_data;
        end
        bus_finish();
        total++; if (acks != 0) begin bad++; $display("FAIL miss_ack got=%0d want=0", acks); end
        total++; if (ord !== 16'h0000) begin bad++; $display("FAIL miss_rdata got=%h want=0000", ord); end
    endtask

    task automatic test_overrun();
        logic [15:0] rd;
        for (int i = 0; i < 17; i++) send_rx_byte(8'h30 + 8'(i), 1'b1);
        repeat (4) @(posedge clk);
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h100F) begin bad++; $display("FAIL overrun_status got=%h want=100f", rd); end
        bus_write(A_STAT, 2'b11, 16'h0008);
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h1007) begin bad++; $display("FAIL overrun_clear got=%h want=1007", rd); end
        bus_read(A_DATA, rd);
        total++; if (rd !== 16'h0030) begin bad++; $display("FAIL overrun_first got=%h want=0030", rd); end
        for (int i = 1; i < 15; i++) bus_read(A_DATA, rd);
        bus_read(A_DATA, rd);
        total++; if (rd !== 16'h003F) begin bad++; $display("FAIL overrun_last got=%h want=003f", rd); end
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0006) begin bad++; $display("FAIL overrun_drained got=%h want=0006", rd); end
    endtask

    task automatic test_frame_err();
        logic [15:0] rd;
        bus_write(A_CTRL, 2'b11, 16'h0001);
        repeat (2) @(negedge clk);
        total++; if (io_irq !== 1'b0) begin bad++; $display("FAIL fe_irq_quiet got=%b want=0", io_irq); end
        send_rx_byte(8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        bus_read(A_STAT, rd);
        total++; if (rd !== 16'h0016) begin bad++; $display("FAIL fe_status got=%h want=0016", rd); end
        total++; if (io_irq !== 1'b1) begin bad++; $display("FAIL fe_irq got=%b want=1", io_irq); end
        // Clearing the flag drops io_irq one clock after the accept edge
        bus_start(A_STAT, 1'b0, 2'b11, 16'h0010);
        bus_wait_ack(rd);
        total++; if (io_irq !== 1'b1) begin bad++; $display("FAIL fe_irq_latency got=%b want=1", io_irq); end
        @(negedge clk);
        total++; if (io_irq !== 1'b0) begin bad++; $display("FAIL fe_irq_cleared got=%b want=0", io_irq); end
        bus_finish();
    endtask

    task automatic test_control_irq();
        logic [15:0] rd;
        bus_write(A_CTRL, 2'b11, 16'h0007);
        bus_read(A_CTRL, rd);
        total++; if (rd !== 16'h0003) begin bad++; $display("FAIL ctrl_readback got=%h want=0003", rd); end
        total++; if (io_irq !== 1'b1) begin bad++; $display("FAIL tx_ien_irq got=%b want=1", io_irq); end
        bus_write(A_CTRL, 2'b11, 16'h0000);
        @(negedge clk);
        total++; if (io_irq !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b want=0", io_irq); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_hold_and_miss();
        test_overrun();
        test_frame_err();
        test_control_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
